// File: rtl/orb_stage_sequencer_if.sv
// rtl/orb_stage_sequencer_if.sv - stage launch/done handshake and params status write bus
interface orb_stage_sequencer_if #(
  parameter int NUM_STAGES  = 4,
  parameter int NUM_PARAMS  = 8,
  parameter int PARAM_DEPTH = 8
);
  logic [NUM_STAGES-1:0]         stage_start;
  logic [NUM_STAGES-1:0]         stage_done;
  logic [$clog2(NUM_PARAMS)-1:0] addr_write_params;
  logic                          wen_params;
  logic [PARAM_DEPTH-1:0]        wdat_params;

  modport master (
    output stage_start,
    output addr_write_params,
    output wen_params,
    output wdat_params,
    input  stage_done
  );

  modport slave (
    input  stage_start,
    input  addr_write_params,
    input  wen_params,
    input  wdat_params,
    output stage_done
  );
endinterface

// File: rtl/orb_stage_sequencer.sv
// rtl/orb_stage_sequencer.sv - in-order frame sequencer with bypass mask, watchdog, abort and one-deep start queue
module orb_stage_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int TIMEOUT_W   = 24,
  parameter int FRAME_CNT_W = 16,
  parameter int NUM_PARAMS  = 8,
  parameter int PARAM_DEPTH = 8,
  parameter int STATUS_ADDR = NUM_PARAMS - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_STAGES-1:0]         stage_en,
  input  logic [TIMEOUT_W-1:0]          timeout_limit,
  input  logic                          abort,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          frame_error,
  output logic [$clog2(NUM_STAGES)-1:0] err_stage,
  output logic                          overrun,
  output logic [FRAME_CNT_W-1:0]        frame_count,
  orb_stage_sequencer_if.master         bus
);

  localparam int ERR_W  = $clog2(NUM_STAGES);
  localparam int ADDR_W = $clog2(NUM_PARAMS);
  localparam int CUR_W  = PARAM_DEPTH - 3;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, REPORT} state_t;

  state_t                state;
  state_t                state_n;
  logic [NUM_STAGES-1:0] rem;
  logic [NUM_STAGES-1:0] pend_mask;
  logic                  pending;
  logic [ERR_W-1:0]      cur;
  logic [ERR_W-1:0]      launch_idx;
  logic [ERR_W-1:0]      rep_idx;
  logic [NUM_STAGES-1:0] launch_onehot;
  logic [TIMEOUT_W-1:0]  wait_cnt;
  logic                  res_ok;
  logic                  res_to;
  logic                  res_ab;
  logic                  rep_ok;
  logic                  rep_to;
  logic                  rep_ab;
  logic                  go_rep;

  function automatic logic [ERR_W-1:0] lowest(input logic [NUM_STAGES-1:0] m);
    lowest = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (m[i]) lowest = ERR_W'(i);
    end
  endfunction

  always_comb begin
    launch_idx    = lowest(rem);
    launch_onehot = NUM_STAGES'(1) << launch_idx;
  end

  always_comb begin
    state_n = state;
    rep_ok  = 1'b0;
    rep_to  = 1'b0;
    rep_ab  = 1'b0;
    rep_idx = cur;
    case (state)
      IDLE: begin
        if (pending || start) state_n = LAUNCH;
      end
      LAUNCH: begin
        rep_idx = launch_idx;
        if (abort) begin
          state_n = REPORT;
          rep_ab  = 1'b1;
        end else if (rem == '0) begin
          state_n = REPORT;
          rep_ok  = 1'b1;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_n = REPORT;
          rep_ab  = 1'b1;
        end else if (bus.stage_done[cur]) begin
          state_n = LAUNCH;
        end else if (timeout_limit != '0 && wait_cnt == timeout_limit) begin
          state_n = REPORT;
          rep_to  = 1'b1;
        end
      end
      REPORT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    go_rep = rep_ok | rep_to | rep_ab;
  end

  // Launch pulse is decoded from rem so it lands in the LAUNCH cycle itself; abort suppresses it.
  assign bus.stage_start       = (state == LAUNCH && rem != '0 && !abort) ? launch_onehot : '0;
  assign busy                  = (state != IDLE) || pending;
  assign frame_done            = (state == REPORT);
  assign frame_error           = (state == REPORT) && !res_ok;
  assign bus.wen_params        = (state == REPORT);
  assign bus.addr_write_params = (state == REPORT) ? ADDR_W'(STATUS_ADDR) : '0;
  assign bus.wdat_params       = (state == REPORT) ? {CUR_W'(cur), res_ab, res_to, res_ok} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      pending     <= 1'b0;
      pend_mask   <= '0;
      cur         <= '0;
      wait_cnt    <= '0;
      res_ok      <= 1'b0;
      res_to      <= 1'b0;
      res_ab      <= 1'b0;
      err_stage   <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      state   <= state_n;
      overrun <= start && pending;

      // A queued frame is served before a new start, so a start landing on a draining IDLE is dropped.
      if (state == IDLE) begin
        if (pending) begin
          rem     <= pend_mask;
          pending <= 1'b0;
        end else if (start) begin
          rem <= stage_en;
        end
      end else if (start && !pending) begin
        pending   <= 1'b1;
        pend_mask <= stage_en;
      end

      if (state == LAUNCH) begin
        cur      <= launch_idx;
        wait_cnt <= '0;
      end

      if (state == WAIT) begin
        if (!abort && bus.stage_done[cur]) rem[cur] <= 1'b0;
        if (wait_cnt != '1) wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      end

      if (go_rep) begin
        res_ok    <= rep_ok;
        res_to    <= rep_to;
        res_ab    <= rep_ab;
        err_stage <= rep_ok ? '0 : rep_idx;
      end

      if (state == REPORT && res_ok) frame_count <= frame_count + FRAME_CNT_W'(1);
    end
  end

endmodule
